// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with a 2-entry elastic output buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    typedef enum logic [2:0] {
        FMT_I     = 3'b000,
        FMT_S     = 3'b001,
        FMT_B     = 3'b010,
        FMT_J     = 3'b011,
        FMT_U     = 3'b100,
        FMT_Z     = 3'b101,
        FMT_SHAMT = 3'b110
    } imm_fmt_e;

    logic [31:0]      w_imm32;
    logic             w_illegal;
    logic [XLEN-1:0]  w_imm;
    logic             w_push;
    logic             w_pop;

    logic [XLEN-1:0]  r_imm_q [2];
    logic [TAG_W-1:0] r_tag_q [2];
    logic             r_ill_q [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    // Every format is built as a 32-bit signed value; Z and SHAMT have bit 31
    // clear, so one sign extension to XLEN serves all formats.
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (imm_src)
            FMT_I:     w_imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:     w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:     w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            FMT_J:     w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            FMT_U:     w_imm32 = {instr[31:12], 12'b0};
            FMT_Z:     w_imm32 = {27'b0, instr[19:15]};
            FMT_SHAMT: w_imm32 = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

    assign in_ready  = (r_count != 2'd2) & ~reset;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                r_imm_q[k] <= '0;
                r_tag_q[k] <= '0;
                r_ill_q[k] <= 1'b0;
            end
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_imm_q[r_wptr] <= w_imm;
                r_tag_q[r_wptr] <= in_tag;
                r_ill_q[r_wptr] <= w_illegal;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty buffer shows zeros so stale slot contents never leak out.
    assign imm_ext = out_valid ? r_imm_q[r_rptr] : '0;
    assign out_tag = out_valid ? r_tag_q[r_rptr] : '0;
    assign illegal = out_valid ? r_ill_q[r_rptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed bench for imm_gen_pipe at XLEN=32 and XLEN=64
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        d32_in_ready, d32_out_valid, d32_illegal;
    logic [31:0] d32_imm;
    logic [7:0]  d32_tag;
    logic        d64_in_ready, d64_out_valid, d64_illegal;
    logic [63:0] d64_imm;
    logic [7:0]  d64_tag;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [7:0]  tag;
        logic        ill;
    } ent_t;

    ent_t q[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d32_in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(d32_out_valid), .out_ready(out_ready),
        .imm_ext(d32_imm), .out_tag(d32_tag), .illegal(d32_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d64_in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(d64_out_valid), .out_ready(out_ready),
        .imm_ext(d64_imm), .out_tag(d64_tag), .illegal(d64_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate value as a signed integer, then truncated to the XLEN width.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input int xlen);
        longint v;
        case (src)
            3'd0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
            3'd1: begin v = longint'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                if (v >= 1048576) v -= 2097152;
            end
            3'd4: begin
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v -= 64'sh1_0000_0000;
            end
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_v;
        logic push, pop;
        ent_t e;
        if (chk_en) begin
            exp_v = (q.size() != 0);
            chk("d32_out_valid", 64'(d32_out_valid), 64'(exp_v));
            chk("d64_out_valid", 64'(d64_out_valid), 64'(exp_v));
            chk("d32_in_ready", 64'(d32_in_ready), 64'((q.size() < 2) && !reset));
            chk("d64_in_ready", 64'(d64_in_ready), 64'((q.size() < 2) && !reset));
            chk("d32_imm", 64'(d32_imm), exp_v ? q[0].i32 : 64'd0);
            chk("d64_imm", d64_imm, exp_v ? q[0].i64 : 64'd0);
            chk("d32_tag", 64'(d32_tag), exp_v ? 64'(q[0].tag) : 64'd0);
            chk("d64_tag", 64'(d64_tag), exp_v ? 64'(q[0].tag) : 64'd0);
            chk("d32_illegal", 64'(d32_illegal), exp_v ? 64'(q[0].ill) : 64'd0);
            chk("d64_illegal", 64'(d64_illegal), exp_v ? 64'(q[0].ill) : 64'd0);
        end
        push = in_valid && (q.size() < 2) && !reset;
        pop  = (q.size() != 0) && out_ready;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.i32 = ref_imm(instr, imm_src, 32);
                e.i64 = ref_imm(instr, imm_src, 64);
                e.tag = in_tag;
                e.ill = (imm_src == 3'd7);
                q.push_back(e);
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] ins,
                         input logic [7:0] t, input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        imm_src   = s;
        instr     = ins;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  dir_src [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd6, 3'd7};
    logic [31:0] dir_ins [9] = '{32'hFFF00093, 32'hFE512E23, 32'hFE000CE3, 32'hFFDFF06F,
                                 32'h123450B7, 32'h000F8073, 32'h80000037, 32'h03F01013,
                                 32'hDEADBEEF};

    initial begin
        drive(0, 3'd0, 32'd0, 8'd0, 1, 0, 1);
        @(posedge clk);
        #1;
        chk_en = 1;
        step();

        chk("pin_I",     ref_imm(32'hFFF00093, 3'd0, 32), 64'h00000000_FFFFFFFF);
        chk("pin_S",     ref_imm(32'hFE512E23, 3'd1, 32), 64'h00000000_FFFFFFFC);
        chk("pin_B",     ref_imm(32'hFE000CE3, 3'd2, 32), 64'h00000000_FFFFFFF8);
        chk("pin_J",     ref_imm(32'hFFDFF06F, 3'd3, 32), 64'h00000000_FFFFFFFC);
        chk("pin_U",     ref_imm(32'h123450B7, 3'd4, 32), 64'h00000000_12345000);
        chk("pin_Z",     ref_imm(32'h000F8073, 3'd5, 32), 64'h00000000_0000001F);
        chk("pin_U64",   ref_imm(32'h80000037, 3'd4, 64), 64'hFFFFFFFF_80000000);
        chk("pin_SH64",  ref_imm(32'h03F01013, 3'd6, 64), 64'h00000000_0000003F);
        chk("pin_SH32",  ref_imm(32'h03F01013, 3'd6, 32), 64'h00000000_0000001F);
        chk("pin_ILL",   ref_imm(32'hDEADBEEF, 3'd7, 64), 64'd0);

        for (int i = 0; i < 9; i++) begin
            drive(1, dir_src[i], dir_ins[i], 8'(i + 1), 1, 0, 0);
            step();
            chk("dir_tag", 64'(d32_tag), 64'(i + 1));
        end
        drive(0, 3'd0, 32'd0, 8'd0, 1, 0, 0);
        step();

        drive(1, 3'd0, 32'h00100093, 8'd1, 0, 0, 0); step();
        drive(1, 3'd0, 32'h00200093, 8'd2, 0, 0, 0); step();
        chk("bp_in_ready_low", 64'(d32_in_ready), 64'd0);
        chk("bp_head1", 64'(d32_tag), 64'd1);
        drive(1, 3'd0, 32'h00300093, 8'd3, 0, 0, 0); step();
        chk("bp_hold_head1", 64'(d32_tag), 64'd1);
        drive(1, 3'd0, 32'h00300093, 8'd3, 1, 0, 0); step();
        chk("bp_in_ready_rise", 64'(d32_in_ready), 64'd1);
        chk("bp_head2", 64'(d32_tag), 64'd2);
        drive(1, 3'd0, 32'h00300093, 8'd3, 1, 0, 0); step();
        chk("bp_head3", 64'(d32_tag), 64'd3);
        drive(0, 3'd0, 32'd0, 8'd0, 1, 0, 0); step();
        chk("bp_drained", 64'(d32_out_valid), 64'd0);

        drive(1, 3'd1, 32'hFE512E23, 8'h40, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            drive(1, 3'd1, 32'hFE512E23 ^ 32'(i << 7), 8'(8'h41 + i), 1, 0, 0);
            step();
            chk("pp_in_ready", 64'(d32_in_ready), 64'd1);
            chk("pp_out_valid", 64'(d32_out_valid), 64'd1);
            chk("pp_order", 64'(d32_tag), 64'(8'h41 + i));
        end
        drive(0, 3'd0, 32'd0, 8'd0, 1, 0, 0); step();

        drive(1, 3'd0, 32'h00500093, 8'h50, 0, 0, 0); step();
        drive(1, 3'd0, 32'h00600093, 8'h51, 0, 0, 0); step();
        drive(1, 3'd0, 32'h00700093, 8'hEE, 0, 1, 0); step();
        chk("fl_out_valid", 64'(d32_out_valid), 64'd0);
        chk("fl_in_ready", 64'(d32_in_ready), 64'd1);
        drive(0, 3'd0, 32'd0, 8'd0, 1, 0, 0); step();
        chk("fl_no_ghost", 64'(d32_out_valid), 64'd0);

        drive(1, 3'd4, 32'h80000037, 8'h60, 0, 0, 0); step();
        drive(1, 3'd4, 32'h80000037, 8'h61, 0, 0, 0); step();
        drive(1, 3'd4, 32'h80000037, 8'h62, 0, 0, 1);
        #1;
        chk("rst_in_ready_low", 64'(d64_in_ready), 64'd0);
        step();
        drive(1, 3'd4, 32'h80000037, 8'h63, 1, 0, 0);
        #1;
        chk("rst_out_valid", 64'(d64_out_valid), 64'd0);
        chk("rst_imm_zero", d64_imm, 64'd0);
        chk("rst_in_ready_high", 64'(d64_in_ready), 64'd1);
        step();
        chk("rst_new_push", 64'(d64_tag), 64'h63);
        chk("rst_new_imm", d64_imm, 64'hFFFFFFFF_80000000);

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                  8'($urandom()), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
            step();
        end
        drive(0, 3'd0, 32'd0, 8'd0, 1, 0, 0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the RISC-V decode path.
- Takes a raw instruction and an immediate-format select, builds the XLEN-wide immediate, and holds it in a 2-entry elastic buffer.
- Uses valid/ready handshakes on both sides and passes a sideband tag through unchanged.
- Sits between fetch/decode and the register-read stage. Replaces the purely combinational extender and adds XLEN=64, CSR/shift formats, illegal-format flagging, backpressure and flush.

Parameters:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- TAG_W, 8, width of the sideband tag (e.g. PC low bits or ROB id) carried with each entry.

Ports:
- clk  in  1  single clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  instr/imm_src/in_tag are valid.
- in_ready  out  1  block can accept an entry this cycle.
- instr  in  32  raw instruction word.
- imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110 SHAMT, 111 reserved.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- imm_ext  out  XLEN  extended immediate of the head entry.
- out_tag  out  TAG_W  tag of the head entry.
- illegal  out  1  head entry had imm_src=111.

Behaviour:
- Immediate build is combinational on input; s = instr[31], all sign fills are to XLEN.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U: sext({instr[31:12], 12'b0}); upper bits are sign-filled when XLEN=64.
  - Z: zero-extend instr[19:15].
  - SHAMT: zero-extend instr[25:20] when XLEN=64; zero-extend instr[24:20] when XLEN=32.
  - 111: imm=0 with illegal=1. No X is ever produced.
- Buffer: 2-entry FIFO holding {imm, tag, illegal}, with registered read/write pointers and a count in 0..2.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1. There is no combinational input-to-output bypass.
- in_ready = (count != 2) & ~reset. It depends on registered state only; there is no combinational path from out_ready.
- out_valid = (count != 0). imm_ext, out_tag and illegal show the head entry, and are 0 when count = 0.
- Simultaneous push and pop with count = 1: count stays 1, the new entry becomes head next cycle, and order is preserved.
- Push and pop with count = 2 cannot occur because in_ready is 0. A pop at count = 2 raises in_ready in the next cycle.
- Holding rule: while out_valid=1 and out_ready=0, the head outputs stay stable.
- flush: on the next edge count becomes 0 and the pointers reset. flush has priority over a push and a pop in the same cycle; that cycle's input is discarded and out_valid=0 next cycle.
- reset: synchronous, highest priority. It clears count, pointers and the storage.
- Reset values: out_valid=0, imm_ext=0, out_tag=0, illegal=0. in_ready=0 while reset is high and 1 on the first cycle after.
- Reset asserted mid-stream drops all entries, and no partial output is produced.
- Storage is held when neither push nor pop occurs. Contents of unused slots are don't-care but are never visible on the outputs.

Test Plan:
- XLEN=32 formats, out_ready=1, one instruction per cycle:
  - I 0xFFF00093 -> 0xFFFFFFFF.
  - S 0xFE512E23 -> 0xFFFFFFFC.
  - B 0xFE000CE3 -> 0xFFFFFFF8.
  - J 0xFFDFF06F -> 0xFFFFFFFC.
  - U 0x123450B7 -> 0x12345000.
  - Z with instr[19:15]=11111 -> 0x0000001F.
  - Each result appears exactly 1 cycle after acceptance, with its tag matching.
- XLEN=64: U 0x80000037 -> 0xFFFFFFFF80000000; SHAMT with instr[25:20]=0x3F -> 0x3F; imm_src=111 -> imm 0, illegal=1.
- Backpressure: out_ready=0, offer tags 1, 2, 3 back-to-back.
  - in_ready drops after 2 accepts and tag 3 is held.
  - Raise out_ready: outputs are tags 1, 2, 3 in order, and in_ready rises 1 cycle after the first pop.
- Simultaneous push/pop at count=1 for 10 cycles: a continuous stream with no bubbles, in_ready is always 1, and order is preserved.
- flush with count=2 and in_valid=1 in the same cycle: next cycle out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
- reset asserted for 1 cycle with 2 entries buffered: during reset in_ready=0; afterwards out_valid=0 and imm_ext=0, and a new push emerges after 1 cycle.
